// File: rtl/alu_pkg.sv
// Shared ALU definitions: decoder control codes, multiply sequencer states and
// the operand magnitude helper.
package alu_pkg;

  localparam int XLEN = 32;

  // 5-bit ALU control codes, shared with the ALU decoder.
  localparam logic [4:0] ALU_AND  = 5'b00000;
  localparam logic [4:0] ALU_OR   = 5'b00001;
  localparam logic [4:0] ALU_XOR  = 5'b00010;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_SLT  = 5'b00101;
  localparam logic [4:0] ALU_SLL  = 5'b00110;
  localparam logic [4:0] ALU_SRL  = 5'b00111;
  localparam logic [4:0] ALU_SRA  = 5'b01000;
  localparam logic [4:0] ALU_MUL  = 5'b01001;
  localparam logic [4:0] ALU_MULH = 5'b01010;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} mul_state_t;

  // Two's-complement magnitude; -2^31 maps onto 0x80000000 read as unsigned.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? -v : v;
  endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Execute-stage <-> multiply sequencer signals. The execute stage is the
// master; the sequencer is the slave.
interface mul_seq_if;
  import alu_pkg::*;

  logic            start;
  logic [4:0]      alucontrol;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, alucontrol, srca, srcb, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, alucontrol, srca, srcb, flush,
    output stall, busy, done, result
  );

endinterface

// File: rtl/mul_step.sv
// One radix-2 shift-add iteration on operand magnitudes.
module mul_step
  import alu_pkg::*;
(
  input  logic [2*XLEN-1:0] acc,
  input  logic [2*XLEN-1:0] mcand,
  input  logic [XLEN-1:0]   mplier,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic [2*XLEN-1:0] mcand_nxt,
  output logic [XLEN-1:0]   mplier_nxt
);

  assign acc_nxt    = mplier[0] ? acc + mcand : acc;
  assign mcand_nxt  = mcand << 1;
  assign mplier_nxt = mplier >> 1;

endmodule

// File: rtl/mul_seq.sv
// Multi-cycle mul/mulh sequencer beside the single-cycle ALU: holds the pipe
// for 34 cycles, then pulses done with the selected product half.
module mul_seq
  import alu_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  mul_seq_if.slave bus
);

  mul_state_t        state;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic [4:0]        count;
  logic              neg;
  logic              hi;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  logic [2*XLEN-1:0] acc_nxt;
  logic [2*XLEN-1:0] mcand_nxt;
  logic [XLEN-1:0]   mplier_nxt;
  logic [2*XLEN-1:0] acc_fix;
  logic              is_mul;
  logic              accept;

  mul_step u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .acc_nxt    (acc_nxt),
    .mcand_nxt  (mcand_nxt),
    .mplier_nxt (mplier_nxt)
  );

  // A flush in the accept cycle cancels the accept, so it must not stall.
  assign is_mul  = (bus.alucontrol == ALU_MUL) || (bus.alucontrol == ALU_MULH);
  assign accept  = (state == IDLE) && bus.start && is_mul && !bus.flush;
  assign acc_fix = neg ? -acc : acc;

  assign bus.stall  = accept || (state == CALC) || (state == SIGN);
  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
      neg      <= 1'b0;
      hi       <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (accept) begin
            mcand  <= {{XLEN{1'b0}}, abs_val(bus.srca)};
            mplier <= abs_val(bus.srcb);
            neg    <= bus.srca[XLEN-1] ^ bus.srcb[XLEN-1];
            hi     <= (bus.alucontrol == ALU_MULH);
            acc    <= '0;
            count  <= '0;
            state  <= CALC;
          end
          CALC: begin
            acc    <= acc_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            count  <= count + 5'd1;
            // 32nd iteration: count wraps to 0 as we leave CALC.
            if (count == 5'd31) state <= SIGN;
          end
          SIGN: begin
            acc      <= acc_fix;
            result_q <= hi ? acc_fix[2*XLEN-1:XLEN] : acc_fix[XLEN-1:0];
            done_q   <= 1'b1;
            state    <= DONE;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: expected products are queued at issue and
// compared when done pulses; cycle-exact stall/busy/done windows are checked.
module tb_mul_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_seq_if bus();

  mul_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_done   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] code, input logic [31:0] a,
                                        input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return (code == ALU_MULH) ? p[63:32] : p[31:0];
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      n_done++;
      if (exp_q.size() == 0) check("spurious_done", 32'd1, 32'd0);
      else                   check("result", bus.result, exp_q.pop_front());
    end
  end

  task automatic drive(input logic s, input logic [4:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic f);
    bus.start      = s;
    bus.alucontrol = c;
    bus.srca       = a;
    bus.srcb       = b;
    bus.flush      = f;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues a multiply in the next cycle (cycle 0) and walks it through cycle 34.
  task automatic run_mul(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                         input bit hold_start);
    int stall_bad = 0;
    int busy_bad  = 0;
    int done_bad  = 0;
    next_cycle();
    check("idle_result", bus.result, last_exp);
    drive(1'b1, c, a, b, 1'b0);
    #1;
    check("accept_stall", 32'(bus.stall), 32'd1);
    check("accept_busy", 32'(bus.busy), 32'd0);
    exp_q.push_back(model(c, a, b));
    last_exp = model(c, a, b);
    for (int k = 1; k <= 33; k++) begin
      next_cycle();
      if (!hold_start) bus.start = 1'b0;
      #1;
      if (bus.stall !== 1'b1) stall_bad++;
      if (bus.busy  !== 1'b1) busy_bad++;
      if (bus.done  !== 1'b0) done_bad++;
    end
    check("stall_window_bad", 32'(stall_bad), 32'd0);
    check("busy_window_bad", 32'(busy_bad), 32'd0);
    check("early_done", 32'(done_bad), 32'd0);
    next_cycle();
    if (!hold_start) bus.start = 1'b0;
    #1;
    check("done_c34", 32'(bus.done), 32'd1);
    check("stall_c34", 32'(bus.stall), 32'd0);
    check("busy_c34", 32'(bus.busy), 32'd1);
  endtask

  initial begin
    int prev_done;
    int bad;
    reset = 1'b1;
    drive(1'b0, ALU_ADD, '0, '0, 1'b0);
    #12;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed products, issued back-to-back (each new accept lands in cycle 35).
    run_mul(ALU_MUL,  32'd7,          32'hFFFF_FFFD, 1'b0);
    run_mul(ALU_MULH, 32'h8000_0000,  32'h8000_0000, 1'b0);
    run_mul(ALU_MUL,  32'h8000_0000,  32'h8000_0000, 1'b0);
    run_mul(ALU_MULH, 32'hFFFF_FFFF,  32'd1,         1'b0);
    run_mul(ALU_MUL,  32'h0001_0000,  32'h0001_0000, 1'b0);
    run_mul(ALU_MULH, 32'h0001_0000,  32'h0001_0000, 1'b0);

    // Non-multiply code never enters the block.
    bad = 0;
    next_cycle();
    drive(1'b1, ALU_ADD, 32'd5, 32'd6, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      if (bus.stall !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
      if (bus.result !== last_exp) bad++;
      next_cycle();
    end
    check("add_bypass_bad", 32'(bad), 32'd0);

    // start held high with mul through cycles 1-34: exactly one done.
    prev_done = n_done;
    run_mul(ALU_MUL, 32'd12345, 32'hFFFF_0001, 1'b1);
    next_cycle();
    drive(1'b0, ALU_ADD, '0, '0, 1'b0);
    #1;
    check("no_reaccept_busy", 32'(bus.busy), 32'd0);
    check("one_done", 32'(n_done - prev_done), 32'd1);

    // Flush in cycle 10 of a mul; the next mul is accepted in cycle 11.
    next_cycle();
    drive(1'b1, ALU_MUL, 32'd100, 32'd200, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      next_cycle();
      bus.start = 1'b0;
    end
    next_cycle();
    bus.flush = 1'b1;
    #1;
    check("flush_c10_busy", 32'(bus.busy), 32'd1);
    run_mul(ALU_MUL, 32'hFFFF_FFF6, 32'd11, 1'b0);

    // Flush coinciding with an accept cancels it.
    next_cycle();
    drive(1'b1, ALU_MUL, 32'd3, 32'd3, 1'b1);
    #1;
    check("flush_accept_stall", 32'(bus.stall), 32'd0);
    next_cycle();
    drive(1'b0, ALU_ADD, '0, '0, 1'b0);
    #1;
    check("flush_accept_busy", 32'(bus.busy), 32'd0);
    check("flush_accept_result", bus.result, last_exp);

    // Asynchronous reset mid-CALC (cycle 20).
    next_cycle();
    drive(1'b1, ALU_MUL, 32'd9, 32'd9, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      next_cycle();
      bus.start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("arst_stall", 32'(bus.stall), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_result", bus.result, 32'd0);
    last_exp = '0;
    @(negedge clk);
    reset = 1'b0;
    run_mul(ALU_MUL, 32'd5, 32'd6, 1'b0);
    check("mul_5x6_model", last_exp, 32'h0000_001E);

    // A few random operand pairs.
    for (int k = 0; k < 4; k++) begin
      run_mul(($urandom_range(0, 1) == 1) ? ALU_MULH : ALU_MUL, $urandom, $urandom, 1'b0);
    end

    next_cycle();
    drive(1'b0, ALU_ADD, '0, '0, 1'b0);
    repeat (3) next_cycle();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Multi-cycle sequencer for the integer multiply operations (mul, mulh) that the ALU decoder selects by control code. It sits beside the single-cycle ALU in the execute stage. When a multiply is issued it holds the pipeline, runs a radix-2 shift-add multiply over 32 iterations, applies sign correction, and returns the selected 32-bit half. All other ALU codes bypass it untouched.

## Interface
- XLEN, 32: operand and result width; only 32 is supported.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  execute stage holds a valid instruction this cycle.
- alucontrol  in  5  ALU control code from the decoder; 5'b01001 = mul, 5'b01010 = mulh.
- srca  in  32  operand A, two's complement.
- srcb  in  32  operand B, two's complement.
- flush  in  1  synchronous abort (branch mispredict or trap).
- stall  out  1  freeze the fetch, decode and execute pipeline registers.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse; result is valid.
- result  out  32  product half selected by the captured code; held until the next accept.

## Operation
- Accept condition: state IDLE and start=1 and alucontrol is 01001 or 01010. Any other code never enters the block.
- On accept, capture:
  - |srca| into the multiplicand (64-bit, zero-extended).
  - |srcb| into the multiplier (32-bit).
  - neg = srca[31] ^ srcb[31].
  - hi = (alucontrol == 01010).
  - acc cleared to 0; count cleared to 0.
- States:
  - IDLE → CALC on accept.
  - CALC: if multiplier[0]=1, acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count += 1. When count == 31 at the clock edge, go to SIGN.
  - SIGN: if neg, acc = -acc (64-bit two's complement). Go to DONE.
  - DONE: done=1; result = hi ? acc[63:32] : acc[31:0], registered on entry to DONE. Go to IDLE.
- mul returns the low 32 bits of the signed×signed product; these equal the unsigned low bits. mulh returns the high 32 bits of the signed×signed product.
- Magnitude of -2^31 is 0x80000000 unsigned. No overflow handling is needed because the 64-bit acc holds every product.
- stall = (IDLE & accept) | CALC | SIGN. stall=0 in DONE so the execute stage advances and captures result.
- start in CALC, SIGN or DONE is ignored (no re-accept).
- flush: in any state, the next state is IDLE, done stays 0, and result is unchanged. A flush in the same cycle as an accept cancels the accept.
- Reset, including mid-operation: state=IDLE, acc=0, count=0, result=0, done=0, stall=0, busy=0.

## Timing
- Accept in cycle 0 (stall already high, combinational from start/alucontrol).
- CALC runs cycles 1–32, SIGN cycle 33, DONE cycle 34. done and result are valid in cycle 34.
- Total stall is 34 cycles (0–33). The instruction retires at the end of cycle 34.
- A back-to-back multiply is presented in cycle 35 (IDLE) and accepted there; there are no bubbles beyond the sequence itself.
- count is 5 bits. The 31→0 wrap coincides with the CALC→SIGN transition and is never observed outside CALC.
- done is strictly a one-cycle pulse. busy is high in cycles 1–34.

## Structure
- Shared package `alu_pkg`:
  - localparams for all 5-bit ALU control codes (add, sub, mul, mulh, …), also used by the ALU decoder.
  - typedef enum logic [1:0] mul_state_t {IDLE, CALC, SIGN, DONE}.
- One sub-module, `mul_step`: combinational single-iteration shift-add (acc, multiplicand, multiplier in → next values out). It keeps the FSM file free of arithmetic and can be unit-tested alone.

## Test plan
- mul 7 × -3: accept at cycle 0 → done in cycle 34, result 0xFFFFFFEB; stall high for cycles 0–33 only.
- mulh 0x80000000 × 0x80000000 → result 0x40000000; the same operands with mul → 0x00000000.
- mulh -1 × 1 → 0xFFFFFFFF; mul 0x0001_0000 × 0x0001_0000 → 0x00000000, and mulh of the same → 0x00000001.
- Non-multiply code (00011, add) with start=1 → stall, busy and done stay 0 and result is unchanged. start=1 with mul during cycles 1–34 → ignored, exactly one done pulse.
- flush in cycle 10 of a mul → IDLE in cycle 11, no done, result keeps its prior value. A new mul accepted in cycle 11 completes normally in cycle 45.
- Asynchronous reset asserted mid-CALC (cycle 20) → all outputs 0 immediately. After release, a mul 5 × 6 completes with result 0x0000001E 34 cycles after its accept.
